// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one full-subtractor slice per clock, LSB first.
// Optional signed-overflow output enabled by defining SUBTRACTOR_OVERFLOW_EN.
module bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUBTRACTOR_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_q, b_q;
    logic             br_q;
    logic [IW-1:0]    idx;
    logic             accept, last_bit;
    logic             a_bit, b_bit, d_bit, br_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first; a missing
    // assignment on any path would infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (idx == LAST_IDX) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign last_bit = (idx == LAST_IDX);

    // One full-subtractor slice on the latched operands.
    assign a_bit   = a_q[idx];
    assign b_bit   = b_q[idx];
    assign d_bit   = a_bit ^ b_bit ^ br_q;
    assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

    // NOTE: these are plain flops (not a RAM), so all of them, including the
    // in-place diff register, take the async reset; an abort leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            br_q       <= 1'b0;
            idx        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SUBTRACTOR_OVERFLOW_EN
            overflow   <= 1'b0;
`endif
        end else if (accept) begin
            a_q  <= a;
            b_q  <= b;
            br_q <= borrow_in;
            idx  <= '0;
        end else if (state == RUN) begin
            diff[idx] <= d_bit;
            br_q      <= br_next;
            if (last_bit) begin
                // idx parks at the MSB until the next accept.
                borrow_out <= br_next;
`ifdef SUBTRACTOR_OVERFLOW_EN
                overflow   <= (a_bit != b_bit) && (d_bit != a_bit);
`endif
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule
